// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: writeback source select, MEM->WB wait-state
// encoding and a helper for sizing the load-wait counter.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2
    } result_src_e;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    // Counter width able to hold LOAD_TIMEOUT; at least one bit so the
    // no-timeout build still has a legal (saturating) counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/pipe_mem_wb_load_wait_fsm.sv
// Load-wait controller for the MEM->WB register. Holds MEM while load data
// is late, drops the load after LOAD_TIMEOUT stall cycles (0 = wait forever)
// and tells the register bank whether to capture or insert a bubble.
module load_wait_fsm
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_m,
    input  logic [1:0] result_src_m,
    input  logic       read_valid_m,
    input  logic       flush_w,
    output logic       mem_stall,
    output logic       capture,
    output logic       timeout_err
);

    localparam int            CW       = cnt_width(LOAD_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LIM  = CW'(LOAD_TIMEOUT);

    wb_state_e     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_set;
    logic          load_pend;
    logic          timeout_hit;

    assign load_pend   = valid_m && (result_src_m == RES_LOAD) && !read_valid_m;
    assign timeout_hit = (LOAD_TIMEOUT != 0) && (cnt == CNT_LIM);

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (err_set)
                timeout_err <= 1'b1;
        end
    end

    // Next state: flush wins over any load-wait bookkeeping
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        if (flush_w) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_pend) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(1);
                    end
                end
                WAIT: begin
                    if (read_valid_m) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else if (timeout_hit) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        err_set   = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs: stall upstream while waiting, capture only a real instruction
    always_comb begin
        mem_stall = 1'b0;
        capture   = 1'b0;
        if (!flush_w) begin
            case (state)
                RUN: begin
                    mem_stall = load_pend;
                    capture   = valid_m && !load_pend;
                end
                WAIT: begin
                    mem_stall = !read_valid_m && !timeout_hit;
                    capture   = read_valid_m;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_mem_wb.sv
// MEM->WB pipeline register with flush, late-load wait state, load timeout
// and writeback result mux. Define PIPE_STATS_EN to build the bubble/retire
// counters; otherwise those ports read as zero.
module pipe_mem_wb
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int REG_AW       = 5,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic [1:0]        result_src_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   read_data_m,
    input  logic              read_valid_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [XLEN-1:0]   pc_plus_4_m,
    input  logic              flush_w,
    output logic              mem_stall,
    output logic              valid_w,
    output logic              reg_write_w,
    output logic [1:0]        result_src_w,
    output logic [XLEN-1:0]   alu_result_w,
    output logic [XLEN-1:0]   read_data_w,
    output logic [REG_AW-1:0] rd_w,
    output logic [XLEN-1:0]   pc_plus_4_w,
    output logic [XLEN-1:0]   result_w,
    output logic              timeout_err,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       retire_cnt
);

    logic capture;

    load_wait_fsm #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .valid_m      (valid_m),
        .result_src_m (result_src_m),
        .read_valid_m (read_valid_m),
        .flush_w      (flush_w),
        .mem_stall    (mem_stall),
        .capture      (capture),
        .timeout_err  (timeout_err)
    );

    // WB register bank: capture a real instruction or load an all-zero bubble.
    // A captured entry is always valid, so reg_write_w is already gated.
    always_ff @(posedge clk) begin
        if (reset || !capture) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            rd_w         <= '0;
            pc_plus_4_w  <= '0;
        end else begin
            valid_w      <= 1'b1;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= read_data_m;
            rd_w         <= rd_m;
            pc_plus_4_w  <= pc_plus_4_m;
        end
    end

    // Writeback source select; the reserved code falls back to the ALU result
    always_comb begin
        case (result_src_w)
            RES_LOAD: result_w = read_data_w;
            RES_PC4:  result_w = pc_plus_4_w;
            default:  result_w = alu_result_w;
        endcase
    end

`ifdef PIPE_STATS_EN
    logic [31:0] bubble_q, retire_q;

    // Every non-reset edge loads either a retiring instruction or a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            retire_q <= '0;
        end else if (capture) begin
            retire_q <= retire_q + 32'd1;
        end else begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_q;
    assign retire_cnt = retire_q;
`else
    assign bubble_cnt = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Scoreboard bench for pipe_mem_wb (LOAD_TIMEOUT=4). Stimulus pushes the
// expected retirement; a negedge monitor pops and compares on valid_w.
module tb_pipe_mem_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, reg_write_m, read_valid_m, flush_w;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic        mem_stall, valid_w, reg_write_w, timeout_err;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus_4_w, result_w;
    logic [4:0]  rd_w;
    logic [31:0] bubble_cnt, retire_cnt;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_mem_wb #(.XLEN(32), .REG_AW(5), .LOAD_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .read_valid_m(read_valid_m), .rd_m(rd_m),
        .pc_plus_4_m(pc_plus_4_m), .flush_w(flush_w), .mem_stall(mem_stall),
        .valid_w(valid_w), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w), .rd_w(rd_w),
        .pc_plus_4_w(pc_plus_4_w), .result_w(result_w), .timeout_err(timeout_err),
        .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic rv, input logic [4:0] rd, input logic [31:0] pc4);
        valid_m      = v;
        reg_write_m  = rw;
        result_src_m = src;
        alu_result_m = alu;
        read_data_m  = rdata;
        read_valid_m = rv;
        rd_m         = rd;
        pc_plus_4_m  = pc4;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic push(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                        input logic [31:0] res);
        exp_t e;
        e.rd = rd; e.rw = rw; e.src = src; e.res = res;
        exp_q.push_back(e);
    endtask

    // Monitor: every retirement must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && valid_w) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_retire: got rd=%0d result=0x%0h expected no retirement",
                         rd_w, result_w);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("retire", {27'd0, rd_w, reg_write_w, result_src_w, result_w},
                      {27'd0, e.rd, e.rw, e.src, e.res});
            end
        end
    end

    initial begin
        int stalls;
        logic [1:0]  src;
        logic [31:0] res;
        logic [31:0] exp_retire;

        reset   = 1'b1;
        flush_w = 1'b0;
        idle();
        tick(); tick();

        // Reset state
        @(negedge clk);
        check("rst_valid_w", valid_w, 0);
        check("rst_fields", {rd_w, reg_write_w, result_src_w, alu_result_w}, 0);
        check("rst_data", {read_data_w, pc_plus_4_w}, 0);
        check("rst_result_w", result_w, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_counters", {bubble_cnt, retire_cnt}, 0);
        tick();
        reset = 1'b0;

        // 1. ALU op
        drive(1'b1, 1'b1, 2'd0, 32'h1234, 32'h0, 1'b0, 5'd5, 32'h100);
        push(5'd5, 1'b1, 2'd0, 32'h1234);
        @(negedge clk);
        check("alu_no_stall", mem_stall, 0);
        tick(); idle(); tick();

        // 2. Load with data ready in the same cycle
        drive(1'b1, 1'b1, 2'd1, 32'h55, 32'hDEADBEEF, 1'b1, 5'd6, 32'h104);
        push(5'd6, 1'b1, 2'd1, 32'hDEADBEEF);
        @(negedge clk);
        check("load_fast_no_stall", mem_stall, 0);
        tick(); idle(); tick();

        // 3. Load with data 3 cycles late
        drive(1'b1, 1'b1, 2'd1, 32'h66, 32'h0, 1'b0, 5'd7, 32'h108);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("late_stall_%0d", i), mem_stall, 1);
            tick();
        end
        read_valid_m = 1'b1;
        read_data_m  = 32'hCAFE;
        push(5'd7, 1'b1, 2'd1, 32'hCAFE);
        @(negedge clk);
        check("late_release", mem_stall, 0);
        tick(); idle(); tick();

        // 5. Flush while waiting
        drive(1'b1, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0, 5'd8, 32'h10C);
        tick(); tick();
        flush_w = 1'b1;
        @(negedge clk);
        check("flush_stall_low", mem_stall, 0);
        tick();
        flush_w = 1'b0;
        idle();
        @(negedge clk);
        check("flush_bubble", valid_w, 0);
        check("flush_no_err", timeout_err, 0);
        check("flush_back_to_run", mem_stall, 0);
        repeat (6) tick();
        @(negedge clk);
        check("flush_err_stays_0", timeout_err, 0);
        tick();

        // 4. Timeout: data never arrives
        drive(1'b1, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0, 5'd9, 32'h110);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            tick();
        end
        check("timeout_stall_cycles", stalls, 4);
        check("timeout_pre_err", timeout_err, 0);
        tick(); idle();
        @(negedge clk);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_bubble", valid_w, 0);
        tick();
        drive(1'b1, 1'b1, 2'd0, 32'h77, 32'h0, 1'b0, 5'd10, 32'h114);
        push(5'd10, 1'b1, 2'd0, 32'h77);
        @(negedge clk);
        check("timeout_run_no_stall", mem_stall, 0);
        tick(); idle(); tick(); tick();
        @(negedge clk);
        check("timeout_err_sticky", timeout_err, 1);
        tick();

        // 6. Reset in WAIT with an ALU op on the inputs
        drive(1'b1, 1'b1, 2'd1, 32'h0, 32'h0, 1'b0, 5'd11, 32'h118);
        tick(); tick();
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 32'h99, 32'h0, 1'b0, 5'd12, 32'h11C);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("rst_wait_valid_w", valid_w, 0);
        check("rst_wait_rd_w", rd_w, 0);
        check("rst_wait_err", timeout_err, 0);
        check("rst_wait_counters", {bubble_cnt, retire_cnt}, 0);
        check("rst_wait_run", mem_stall, 0);

        // Ten back-to-back ops covering every result_src code
        for (int i = 0; i < 10; i++) begin
            src = 2'(i);
            case (src)
                2'd1:    res = 32'hD000 + 32'(i);
                2'd2:    res = 32'h4000 + 32'(i * 4);
                default: res = 32'hA000 + 32'(i);
            endcase
            drive(1'b1, (i != 3), src, 32'hA000 + 32'(i), 32'hD000 + 32'(i), 1'b1,
                  5'(i + 1), 32'h4000 + 32'(i * 4));
            push(5'(i + 1), (i != 3), src, res);
            tick();
        end
        idle();
`ifdef PIPE_STATS_EN
        exp_retire = 32'd10;
`else
        exp_retire = 32'd0;
`endif
        @(negedge clk);
        check("retire_cnt", retire_cnt, exp_retire);
        check("bubble_cnt", bubble_cnt, 0);
        tick(); tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
